xt_keyboard_receiver: RTL and testbench

PS/2 keyboard serial receiver for the PC/XT chipset. It deserialises 11-bit PS/2 device-to-host frames into a scancode byte, which feeds the 8255 port A input (port_a_in). It also raises IRQ1 to the interrupt controller. The host acknowledges a byte by pulsing 8255 port B bit 7 (clear_keyboard). Port B bit 6 (keyboard_clock_enable) gates reception, as on the original XT motherboard.

---
 rtl/xt_keyboard_receiver_if.sv | 32 +++
 rtl/xt_keyboard_receiver.sv | 210 +++++++++++++++++++++
 tb/tb_xt_keyboard_receiver.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/xt_keyboard_receiver_if.sv
// Host-side (8255 / interrupt controller) signal bundle of the XT keyboard receiver.
// parity_error exists only when KBD_PARITY_CHECK_EN is defined.
interface xt_keyboard_receiver_if;
  logic       clear_keyboard;
  logic       keyboard_clock_enable;
  logic [7:0] scancode;
  logic       irq1;
  logic       overrun;
`ifdef KBD_PARITY_CHECK_EN
  logic       parity_error;

  modport master (
    output clear_keyboard, keyboard_clock_enable,
    input  scancode, irq1, overrun, parity_error
  );

  modport slave (
    input  clear_keyboard, keyboard_clock_enable,
    output scancode, irq1, overrun, parity_error
  );
`else
  modport master (
    output clear_keyboard, keyboard_clock_enable,
    input  scancode, irq1, overrun
  );

  modport slave (
    input  clear_keyboard, keyboard_clock_enable,
    output scancode, irq1, overrun
  );
`endif
endinterface

// File: rtl/xt_keyboard_receiver.sv
// PS/2 device-to-host frame receiver feeding the XT 8255 port A and IRQ1.
// Optional odd-parity enforcement and parity_error output: define KBD_PARITY_CHECK_EN.
module xt_keyboard_receiver #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned TIMEOUT_CYCLES  = 20000
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   ps2_clock,
  input  logic                   ps2_data,
  output logic                   ps2_clock_inhibit,
  xt_keyboard_receiver_if.slave  host
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic       clk_meta, clk_sync;
  logic       dat_meta, dat_sync;
  logic       filt_clk;
  logic [7:0] deb_cnt;
  logic       fall_strobe;

  state_t      state, state_next;
  logic [2:0]  bit_cnt;
  logic [7:0]  shift_reg;
  logic [15:0] timeout_cnt;
  logic        timeout_hit;
  logic        frame_done;

  logic [7:0] scancode_q;
  logic       irq1_q;
  logic       overrun_q;

`ifdef KBD_PARITY_CHECK_EN
  logic parity_bit;
  logic parity_bad;
  logic parity_error_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would turn the 2-flop synchroniser into one flop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_meta <= 1'b1;
      clk_sync <= 1'b1;
      dat_meta <= 1'b1;
      dat_sync <= 1'b1;
    end else begin
      clk_meta <= ps2_clock;
      clk_sync <= clk_meta;
      dat_meta <= ps2_data;
      dat_sync <= dat_meta;
    end
  end

  // Filtered clock flips on the DEBOUNCE_CYCLES-th consecutive differing sample;
  // the falling-edge strobe is registered alongside the flip.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      filt_clk    <= 1'b1;
      deb_cnt     <= '0;
      fall_strobe <= 1'b0;
    end else begin
      fall_strobe <= 1'b0;
      if (clk_sync == filt_clk) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DEB_LAST) begin
        filt_clk    <= clk_sync;
        deb_cnt     <= '0;
        fall_strobe <= filt_clk;
      end else begin
        deb_cnt <= deb_cnt + 8'd1;
      end
    end
  end

  assign timeout_hit = (state != S_IDLE) && (timeout_cnt == TO_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    if (!host.keyboard_clock_enable || timeout_hit) begin
      state_next = S_IDLE;
    end else if (fall_strobe) begin
      case (state)
        S_IDLE:   if (!dat_sync) state_next = S_DATA;
        S_DATA:   if (bit_cnt == 3'd7) state_next = S_PARITY;
        S_PARITY: state_next = S_STOP;
        S_STOP:   state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_done = 1'b0;
`ifdef KBD_PARITY_CHECK_EN
    parity_bad = 1'b0;
`endif
    if (host.keyboard_clock_enable && !timeout_hit && fall_strobe && state == S_STOP) begin
`ifdef KBD_PARITY_CHECK_EN
      parity_bad = ~(^shift_reg ^ parity_bit);
      frame_done = dat_sync && !parity_bad;
`else
      frame_done = dat_sync;
`endif
    end
  end

  // Frame assembly: bit counter, LSB-first shift register, parity capture, timeout.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt     <= '0;
      shift_reg   <= '0;
      timeout_cnt <= '0;
`ifdef KBD_PARITY_CHECK_EN
      parity_bit  <= 1'b0;
`endif
    end else begin
      if (state != S_DATA) begin
        bit_cnt <= '0;
      end else if (fall_strobe && state_next != S_IDLE) begin
        bit_cnt <= bit_cnt + 3'd1;
      end

      if (fall_strobe && state == S_DATA && state_next != S_IDLE) begin
        shift_reg <= {dat_sync, shift_reg[7:1]};
      end

`ifdef KBD_PARITY_CHECK_EN
      if (fall_strobe && state == S_PARITY && state_next == S_STOP) begin
        parity_bit <= dat_sync;
      end
`endif

      if (state == S_IDLE || !host.keyboard_clock_enable || fall_strobe || timeout_hit) begin
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + 16'd1;
      end
    end
  end

  // Host-visible byte latch; clear_keyboard wins over a frame completing in the same cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scancode_q     <= '0;
      irq1_q         <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      parity_error_q <= 1'b0;
`endif
    end else if (host.clear_keyboard) begin
      scancode_q     <= '0;
      irq1_q         <= 1'b0;
      overrun_q      <= 1'b0;
`ifdef KBD_PARITY_CHECK_EN
      parity_error_q <= 1'b0;
`endif
    end else begin
      if (frame_done) begin
        if (irq1_q) begin
          overrun_q <= 1'b1;
        end else begin
          scancode_q <= shift_reg;
          irq1_q     <= 1'b1;
        end
      end
`ifdef KBD_PARITY_CHECK_EN
      if (parity_bad) begin
        parity_error_q <= 1'b1;
      end
`endif
    end
  end

  // Hold the device off while disabled or while a byte is waiting for the host.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ps2_clock_inhibit <= 1'b1;
    end else begin
      ps2_clock_inhibit <= ~host.keyboard_clock_enable | irq1_q | host.clear_keyboard;
    end
  end

  assign host.scancode = scancode_q;
  assign host.irq1     = irq1_q;
  assign host.overrun  = overrun_q;
`ifdef KBD_PARITY_CHECK_EN
  assign host.parity_error = parity_error_q;
`endif

endmodule

// File: tb/tb_xt_keyboard_receiver.sv
// Self-checking bench for xt_keyboard_receiver: directed steps plus random frames
// against a frame-level reference model. PS/2 bit time is scaled to 80 system clocks.
module tb_xt_keyboard_receiver;

  localparam int HALF = 40;          // half PS/2 clock period in system clocks
  localparam int LAT  = 11;          // ps2_clock fall -> load visible: 2 sync + 8 debounce + strobe
  localparam int TIMEOUT_CYCLES = 20000;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;
  logic ps2_clock = 1'b1;
  logic ps2_data  = 1'b1;
  logic ps2_clock_inhibit;

  xt_keyboard_receiver_if host ();

  xt_keyboard_receiver dut (
    .clock             (clock),
    .reset_n           (reset_n),
    .ps2_clock         (ps2_clock),
    .ps2_data          (ps2_data),
    .ps2_clock_inhibit (ps2_clock_inhibit),
    .host              (host)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model of the host-visible state
  logic [7:0] m_scancode = 8'h00;
  logic       m_irq1     = 1'b0;
  logic       m_overrun  = 1'b0;
  logic       m_perr     = 1'b0;

  logic [7:0] rd;
  logic       rp, rs;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  task automatic model_frame(input logic [7:0] d, input logic p, input logic stop, input logic en);
    if (!en || !stop) return;
`ifdef KBD_PARITY_CHECK_EN
    if ((^d ^ p) != 1'b1) begin
      m_perr = 1'b1;
      return;
    end
`endif
    if (m_irq1) begin
      m_overrun = 1'b1;
    end else begin
      m_scancode = d;
      m_irq1     = 1'b1;
    end
  endtask

  task automatic model_clear();
    m_scancode = 8'h00;
    m_irq1     = 1'b0;
    m_overrun  = 1'b0;
    m_perr     = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".scancode"}, host.scancode, m_scancode);
    check({tag, ".irq1"}, {7'd0, host.irq1}, {7'd0, m_irq1});
    check({tag, ".overrun"}, {7'd0, host.overrun}, {7'd0, m_overrun});
    check({tag, ".inhibit"}, {7'd0, ps2_clock_inhibit}, {7'd0, m_irq1});
`ifdef KBD_PARITY_CHECK_EN
    check({tag, ".parity_error"}, {7'd0, host.parity_error}, {7'd0, m_perr});
`endif
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    tick(HALF);
    ps2_clock = 1'b0;
    tick(HALF);
    ps2_clock = 1'b1;
  endtask

  // A bit whose high and low phases each carry a 2-cycle glitch
  task automatic glitch_bit(input logic b);
    ps2_data = b;
    tick(10);
    ps2_clock = 1'b0;
    tick(2);
    ps2_clock = 1'b1;
    tick(HALF - 12);
    ps2_clock = 1'b0;
    tick(10);
    ps2_clock = 1'b1;
    tick(2);
    ps2_clock = 1'b0;
    tick(HALF - 12);
    ps2_clock = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] d, input logic p);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic stop);
    send_head(d, p);
    ps2_bit(stop);
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic clear_pulse(input int n);
    host.clear_keyboard = 1'b1;
    tick(n);
    host.clear_keyboard = 1'b0;
    tick(2);
    model_clear();
  endtask

  initial begin
    host.clear_keyboard        = 1'b0;
    host.keyboard_clock_enable = 1'b1;

    // Reset state
    tick(3);
    check("reset.scancode", host.scancode, 8'h00);
    check("reset.irq1", {7'd0, host.irq1}, 8'h00);
    check("reset.overrun", {7'd0, host.overrun}, 8'h00);
    check("reset.inhibit", {7'd0, ps2_clock_inhibit}, 8'h01);
    reset_n = 1'b1;
    tick(2);
    check_model("post_reset");

    // 1: 0x1C with exact load latency after the stop-bit falling edge
    send_head(8'h1C, 1'b0);
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clock = 1'b0;
    tick(LAT - 1);
    check("t1.irq1_before", {7'd0, host.irq1}, 8'h00);
    tick(1);
    check("t1.irq1_load", {7'd0, host.irq1}, 8'h01);
    check("t1.scancode_load", host.scancode, 8'h1C);
    check("t1.inhibit_same", {7'd0, ps2_clock_inhibit}, 8'h00);
    tick(1);
    check("t1.inhibit_next", {7'd0, ps2_clock_inhibit}, 8'h01);
    tick(HALF - LAT - 1);
    ps2_clock = 1'b1;
    tick(HALF);
    model_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check_model("t1");

    // 2: overrun while pending, then 3-cycle clear
    send_frame(8'h9C, odd_par(8'h9C), 1'b1);
    model_frame(8'h9C, odd_par(8'h9C), 1'b1, 1'b1);
    check_model("t2.overrun");
    host.clear_keyboard = 1'b1;
    tick(3);
    model_clear();
    check("t2.clr.scancode", host.scancode, 8'h00);
    check("t2.clr.irq1", {7'd0, host.irq1}, 8'h00);
    check("t2.clr.overrun", {7'd0, host.overrun}, 8'h00);
    host.clear_keyboard = 1'b0;
    check("t2.inhibit_held", {7'd0, ps2_clock_inhibit}, 8'h01);
    tick(1);
    check("t2.inhibit_drop", {7'd0, ps2_clock_inhibit}, 8'h00);

    // 3: glitches shorter than the debounce window
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3 || i == 6) glitch_bit(rd_const(8'h2A, i));
      else ps2_bit(rd_const(8'h2A, i));
    end
    ps2_bit(odd_par(8'h2A));
    ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(HALF);
    model_frame(8'h2A, odd_par(8'h2A), 1'b1, 1'b1);
    check_model("t3.glitch");
    clear_pulse(2);

    // 4: abandoned partial frame followed by a clean one
    ps2_bit(1'b0);
    for (int i = 0; i < 5; i++) ps2_bit(1'b1);
    ps2_data = 1'b1;
    tick(TIMEOUT_CYCLES + 10);
    check_model("t4.partial");
    send_frame(8'h3B, odd_par(8'h3B), 1'b1);
    model_frame(8'h3B, odd_par(8'h3B), 1'b1, 1'b1);
    check_model("t4.after_timeout");
    clear_pulse(2);

    // 5a: reception disabled
    host.keyboard_clock_enable = 1'b0;
    tick(2);
    check("t5.inhibit_dis", {7'd0, ps2_clock_inhibit}, 8'h01);
    send_frame(8'h45, odd_par(8'h45), 1'b1);
    model_frame(8'h45, odd_par(8'h45), 1'b1, 1'b0);
    check("t5.irq1_dis", {7'd0, host.irq1}, 8'h00);
    check("t5.inhibit_dis2", {7'd0, ps2_clock_inhibit}, 8'h01);
    host.keyboard_clock_enable = 1'b1;
    tick(2);
    check_model("t5.reenabled");

    // 5b: clear_keyboard exactly on the completion cycle
    send_head(8'h77, odd_par(8'h77));
    ps2_data = 1'b1;
    tick(HALF);
    ps2_clock = 1'b0;
    tick(LAT - 1);
    host.clear_keyboard = 1'b1;
    tick(1);
    host.clear_keyboard = 1'b0;
    check("t5.clr_race.irq1", {7'd0, host.irq1}, 8'h00);
    tick(3);
    check("t5.clr_race.irq1_late", {7'd0, host.irq1}, 8'h00);
    check("t5.clr_race.scancode", host.scancode, 8'h00);
    tick(HALF - LAT - 3);
    ps2_clock = 1'b1;
    tick(HALF);
    check_model("t5.clr_race");

`ifdef KBD_PARITY_CHECK_EN
    // 6: bad parity rejected, good parity accepted
    send_frame(8'h1C, 1'b1, 1'b1);
    model_frame(8'h1C, 1'b1, 1'b1, 1'b1);
    check_model("t6.bad_parity");
    clear_pulse(2);
    send_frame(8'h1C, 1'b0, 1'b1);
    model_frame(8'h1C, 1'b0, 1'b1, 1'b1);
    check_model("t6.good_parity");
    clear_pulse(2);
`endif

    // Random frames: arbitrary bytes, occasional bad stop/parity, random clears
    for (int n = 0; n < 12; n++) begin
      rd = 8'($urandom);
      rs = ($urandom_range(0, 7) != 0);
      rp = ($urandom_range(0, 5) == 0) ? ~odd_par(rd) : odd_par(rd);
      send_frame(rd, rp, rs);
      model_frame(rd, rp, rs, 1'b1);
      check_model("rand");
      if ($urandom_range(0, 2) == 0) begin
        clear_pulse(2);
        check_model("rand.clear");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  function automatic logic rd_const(input logic [7:0] d, input int i);
    return d[i];
  endfunction

endmodule
